snake_body_ctrl: RTL and testbench
==================================

# snake_body_ctrl

Snake body generator and movement controller. It owns the packed segment position vectors and the snake length that the collision checker and the renderer consume. It advances the snake one grid step per `move_tick`, applies player direction changes with reversal protection, and grows the body on request. Playfield edges wrap around. All movement freezes while the game is halted on a win or a loss.

## Interface
Parameters:
- `SEG_MAX`, 23: number of segment slots; segment 0 is the head.
- `COORD_W`, 11: coordinate width in bits.
- `STEP`, 20: grid pitch in pixels; one move changes the head by one `STEP`.
- `X_MAX`, 620: largest legal head x. Legal x range is 0..`X_MAX`, in multiples of `STEP`.
- `Y_MAX`, 460: largest legal head y. Legal y range is 0..`Y_MAX`, in multiples of `STEP`.
- `START_X`, 320 and `START_Y`, 240: head position at reset.
- `START_LEN`, 3: length at reset. Legal range is 1..`SEG_MAX`.

Ports (clock and reset first):
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `move_tick`  in  1  one-cycle pulse; requests one step.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each  level direction requests, already debounced.
- `grow`  in  1  one-cycle pulse; the apple was eaten.
- `halt`  in  1  level; the game has ended (lose or win). Blocks moves and grow capture.
- `snakepos_x`  out  `SEG_MAX*COORD_W` (253)  packed x coordinates; segment i is at `[COORD_W*i +: COORD_W]`.
- `snakepos_y`  out  253  packed y coordinates, same packing as `snakepos_x`.
- `length`  out  6  number of live segments.
- `head_dir`  out  2  committed direction: 0 = up, 1 = down, 2 = left, 3 = right.
- `moved`  out  1  one-cycle pulse, high in the cycle the new positions appear.

## Operation
- **Reset values**
  - Head = (`START_X`, `START_Y`).
  - Segment i for 1 ≤ i < `START_LEN` = (`START_X` − i·`STEP`, `START_Y`).
  - Segment i ≥ `START_LEN` = (11'h7FF, 11'h7FF). This is the dead-slot sentinel.
  - `length` = `START_LEN`, `head_dir` = 3 (right), `moved` = 0, pending grow cleared, pending direction = right.
- **Direction FSM**
  - States: UP, DOWN, LEFT, RIGHT.
  - Each cycle, the pending direction loads from the buttons with priority up > down > left > right.
  - A request that is the exact reverse of the committed `head_dir` is ignored.
  - With no button pressed, the pending direction holds.
  - The committed `head_dir` changes only on an accepted move.
  - A button asserted in the same cycle as `move_tick` takes effect on that move, subject to the reversal check.
  - Multiple button presses between moves: the last legal press wins.
- **Grow**
  - A `grow` pulse while `halt` = 0 sets `grow_pend`.
  - The next accepted move consumes `grow_pend`: `length` <= `length` + 1, saturating at `SEG_MAX`. A pulse at saturation is consumed with no change.
  - `grow` and `move_tick` in the same cycle: the growth applies to that move.
- **Move** (on `move_tick` = 1 while `halt` = 0, accepted in one cycle)
  - Shift: segment i <= segment i−1 for i = 1..`SEG_MAX`−1.
  - New head = old head ± `STEP` in the new committed direction.
  - Slots with index ≥ the new length are forced to the sentinel.
  - On growth, the old tail survives as the new last live segment.
- **Wrap-around**
  - Right at x = `X_MAX` goes to x = 0; left at x = 0 goes to x = `X_MAX`.
  - Down at y = `Y_MAX` goes to y = 0; up at y = 0 goes to y = `Y_MAX`.
  - Arithmetic is `COORD_W` bits unsigned. Compare against the limit before adding or subtracting; never rely on overflow.
- **Halt**: `move_tick` is ignored, `grow` is not captured, and all outputs hold. Any `grow_pend` captured before halt is retained.
- **Self-collision** detection is not this block's job; overlapping segments are produced as-is.

## Timing
- All outputs are registered.
- `move_tick` sampled at edge N: new positions, `length`, `head_dir` and `moved` = 1 are visible after edge N (1-cycle latency).
- `moved` lasts exactly one cycle.
- Back-to-back `move_tick` on consecutive cycles gives one step per cycle.
- `reset` has priority over everything. Reset coincident with `move_tick` or `grow` gives the reset values, with no move and no pending grow.
- Positions change only on an accepted move or on reset.

## Test plan
- **Reset and first move.** Apply reset, then `move_tick`.
  - After reset: head (320,240), seg1 (300,240), seg2 (280,240), seg3 = 7FF/7FF, `length` = 3.
  - After the move: head (340,240), seg1 (320,240), seg2 (300,240), `moved` pulses for 1 cycle.
- **Reversal rejection.** With `head_dir` = right, hold `btn_left` and tick → head x increases by 20, `head_dir` stays 3. Then `btn_up` and tick → head y decreases by 20, `head_dir` = 0.
- **Grow.** `grow` in the same cycle as `move_tick` → `length` = 4, seg3 = old seg2. `grow` alone, then a tick 5 cycles later → `length` increments only on that tick. 21 grows starting from length 3 → `length` saturates at 23.
- **Wrap.** Move the head to (620,240) heading right, then tick → head (0,240). Move the head to (0,0) heading up, then tick → head (0,460).
- **Halt.** `halt` = 1 with `move_tick` and `grow` pulses → outputs unchanged and no `moved`. Release `halt`, then tick → exactly one step and no growth.
- **Reset mid-game.** Grow to length 6, then assert reset together with `move_tick` → the exact reset values, with `moved` = 0.

Source files
------------

// File: rtl/snake_body_ctrl.sv
// Snake body generator: owns the segment position vectors, length and heading.
// Advances one grid step per move tick with wrap-around, reversal protection and growth.
module snake_body_ctrl #(
    parameter int SEG_MAX   = 23,
    parameter int COORD_W   = 11,
    parameter int STEP      = 20,
    parameter int X_MAX     = 620,
    parameter int Y_MAX     = 460,
    parameter int START_X   = 320,
    parameter int START_Y   = 240,
    parameter int START_LEN = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       move_tick_i,
    input  logic                       btn_up_i,
    input  logic                       btn_down_i,
    input  logic                       btn_left_i,
    input  logic                       btn_right_i,
    input  logic                       grow_i,
    input  logic                       halt_i,
    output logic [SEG_MAX*COORD_W-1:0] snakepos_x_o,
    output logic [SEG_MAX*COORD_W-1:0] snakepos_y_o,
    output logic [5:0]                 length_o,
    output logic [1:0]                 head_dir_o,
    output logic                       moved_o
);

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_e;

    localparam logic [COORD_W-1:0] STEP_C   = COORD_W'(STEP);
    localparam logic [COORD_W-1:0] X_MAX_C  = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] Y_MAX_C  = COORD_W'(Y_MAX);
    localparam logic [COORD_W-1:0] SENTINEL = '1;
    localparam logic [5:0]         SEG_MAX_C = 6'(SEG_MAX);

    dir_e dir_q, dir_d, pend_q, pend_d, req_dir, sel_dir;
    logic req_valid, accept, grow_now;
    logic [5:0] len_q, len_d;
    logic grow_pend_q, grow_pend_d, moved_q, moved_d;
    logic [COORD_W-1:0] head_x, head_y;
    logic [COORD_W-1:0] pos_x_q [SEG_MAX];
    logic [COORD_W-1:0] pos_y_q [SEG_MAX];
    logic [COORD_W-1:0] pos_x_d [SEG_MAX];
    logic [COORD_W-1:0] pos_y_d [SEG_MAX];

    // Opposite directions differ only in bit 0, so the reverse is a single bit flip.
    always_comb begin
        req_valid = 1'b1;
        if (btn_up_i)         req_dir = UP;
        else if (btn_down_i)  req_dir = DOWN;
        else if (btn_left_i)  req_dir = LEFT;
        else if (btn_right_i) req_dir = RIGHT;
        else begin
            req_dir   = pend_q;
            req_valid = 1'b0;
        end
        sel_dir = (req_valid && (req_dir != dir_e'(dir_q ^ 2'b01))) ? req_dir : pend_q;
    end

    always_comb begin
        head_x = pos_x_q[0];
        head_y = pos_y_q[0];
        unique case (sel_dir)
            UP:    head_y = (pos_y_q[0] == '0)      ? Y_MAX_C : pos_y_q[0] - STEP_C;
            DOWN:  head_y = (pos_y_q[0] >= Y_MAX_C) ? '0      : pos_y_q[0] + STEP_C;
            LEFT:  head_x = (pos_x_q[0] == '0)      ? X_MAX_C : pos_x_q[0] - STEP_C;
            RIGHT: head_x = (pos_x_q[0] >= X_MAX_C) ? '0      : pos_x_q[0] + STEP_C;
            default: ;
        endcase
    end

    always_comb begin
        accept      = move_tick_i && !halt_i;
        grow_now    = grow_pend_q || grow_i;
        len_d       = len_q;
        dir_d       = dir_q;
        pend_d      = sel_dir;
        grow_pend_d = grow_pend_q;
        moved_d     = accept;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        if (accept) begin
            if (grow_now && (len_q < SEG_MAX_C)) len_d = len_q + 6'd1;
            dir_d       = sel_dir;
            grow_pend_d = 1'b0;
            pos_x_d[0]  = head_x;
            pos_y_d[0]  = head_y;
            // Slots beyond the new length become dead; on growth the old tail stays live.
            for (int i = 1; i < SEG_MAX; i++) begin
                pos_x_d[i] = (6'(i) < len_d) ? pos_x_q[i-1] : SENTINEL;
                pos_y_d[i] = (6'(i) < len_d) ? pos_y_q[i-1] : SENTINEL;
            end
        end else if (!halt_i && grow_i) begin
            grow_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SEG_MAX; i++) begin
                pos_x_q[i] <= (i < START_LEN) ? COORD_W'(START_X - i*STEP) : SENTINEL;
                pos_y_q[i] <= (i < START_LEN) ? COORD_W'(START_Y) : SENTINEL;
            end
            len_q       <= 6'(START_LEN);
            dir_q       <= RIGHT;
            pend_q      <= RIGHT;
            grow_pend_q <= 1'b0;
            moved_q     <= 1'b0;
        end else begin
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            len_q       <= len_d;
            dir_q       <= dir_d;
            pend_q      <= pend_d;
            grow_pend_q <= grow_pend_d;
            moved_q     <= moved_d;
        end
    end

    for (genvar g = 0; g < SEG_MAX; g++) begin : g_pack
        assign snakepos_x_o[COORD_W*g +: COORD_W] = pos_x_q[g];
        assign snakepos_y_o[COORD_W*g +: COORD_W] = pos_y_q[g];
    end

    assign length_o   = len_q;
    assign head_dir_o = dir_q;
    assign moved_o    = moved_q;

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Self-checking bench for snake_body_ctrl: directed steps plus random traffic
// compared against a queue-based model of the snake body.
module tb_snake_body_ctrl;

    localparam int SEG = 23;
    localparam int CW  = 11;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic move_tick = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic grow = 1'b0, halt = 1'b0;
    logic [SEG*CW-1:0] snakepos_x, snakepos_y;
    logic [5:0] length;
    logic [1:0] head_dir;
    logic moved;

    int checks = 0;
    int errors = 0;

    int bx[$];
    int by[$];
    int mlen, mdir, mpend, mgrow, mmoved;

    snake_body_ctrl dut (
        .clk(clk), .reset(reset), .move_tick_i(move_tick),
        .btn_up_i(btn_up), .btn_down_i(btn_down), .btn_left_i(btn_left), .btn_right_i(btn_right),
        .grow_i(grow), .halt_i(halt),
        .snakepos_x_o(snakepos_x), .snakepos_y_o(snakepos_y),
        .length_o(length), .head_dir_o(head_dir), .moved_o(moved)
    );

    always #5 clk = ~clk;

    function automatic int revDir(input int d);
        case (d)
            0: return 1;
            1: return 0;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    task automatic modelReset();
        bx.delete();
        by.delete();
        for (int i = 0; i < 3; i++) begin
            bx.push_back(320 - 20*i);
            by.push_back(240);
        end
        mlen = 3; mdir = 3; mpend = 3; mgrow = 0; mmoved = 0;
    endtask

    // The playfield is a torus of 32 x 24 cells, so wrap is just modulo arithmetic.
    task automatic modelStep(input bit mv, u, dn, l, r, g, h, rst);
        int req, sel, nx, ny, nl;
        if (rst) begin
            modelReset();
            return;
        end
        req = -1;
        if (u) req = 0; else if (dn) req = 1; else if (l) req = 2; else if (r) req = 3;
        sel = (req >= 0 && req != revDir(mdir)) ? req : mpend;
        if (mv && !h) begin
            nx = bx[0]; ny = by[0];
            case (sel)
                0: ny = (ny - 20 + 480) % 480;
                1: ny = (ny + 20) % 480;
                2: nx = (nx - 20 + 640) % 640;
                default: nx = (nx + 20) % 640;
            endcase
            nl = mlen;
            if ((mgrow != 0 || g) && mlen < SEG) nl = mlen + 1;
            bx.push_front(nx);
            by.push_front(ny);
            while (bx.size() > nl) begin
                void'(bx.pop_back());
                void'(by.pop_back());
            end
            mlen = nl; mdir = sel; mgrow = 0; mmoved = 1;
        end else begin
            mmoved = 0;
            if (!h && g) mgrow = 1;
        end
        mpend = sel;
    endtask

    task automatic checkVal(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [SEG*CW-1:0] ex, ey;
        for (int i = 0; i < SEG; i++) begin
            ex[CW*i +: CW] = (i < bx.size()) ? CW'(bx[i]) : 11'h7FF;
            ey[CW*i +: CW] = (i < by.size()) ? CW'(by[i]) : 11'h7FF;
        end
        checks++;
        assert (snakepos_x === ex) else begin
            errors++;
            $error("[TB] FAIL %s snakepos_x observed %h expected %h", tag, snakepos_x, ex);
        end
        checks++;
        assert (snakepos_y === ey) else begin
            errors++;
            $error("[TB] FAIL %s snakepos_y observed %h expected %h", tag, snakepos_y, ey);
        end
        checkVal({tag, " length"}, int'(length), mlen);
        checkVal({tag, " head_dir"}, int'(head_dir), mdir);
        checkVal({tag, " moved"}, int'(moved), mmoved);
    endtask

    task automatic applyStimulus(input string tag, input bit mv, u, dn, l, r, g, h, rst);
        move_tick = mv; btn_up = u; btn_down = dn; btn_left = l; btn_right = r;
        grow = g; halt = h; reset = rst;
        @(posedge clk);
        modelStep(mv, u, dn, l, r, g, h, rst);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        int guard;

        applyStimulus("reset0", 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus("reset_tick", 1, 0, 0, 0, 0, 1, 0, 1);
        checkVal("reset head x", int'(snakepos_x[10:0]), 320);
        checkVal("reset seg2 x", int'(snakepos_x[32:22]), 280);
        checkVal("reset seg3 x", int'(snakepos_x[43:33]), 2047);

        applyStimulus("first_move", 1, 0, 0, 0, 0, 0, 0, 0);
        checkVal("first move head x", int'(snakepos_x[10:0]), 340);
        checkVal("first move moved", int'(moved), 1);
        applyStimulus("idle", 0, 0, 0, 0, 0, 0, 0, 0);

        applyStimulus("hold_left", 0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus("left_tick", 1, 0, 0, 1, 0, 0, 0, 0);
        checkVal("reversal head x", int'(snakepos_x[10:0]), 360);
        applyStimulus("up_tick", 1, 1, 0, 0, 0, 0, 0, 0);
        checkVal("turn up head y", int'(snakepos_y[10:0]), 220);

        applyStimulus("grow_tick", 1, 0, 0, 0, 0, 1, 0, 0);
        checkVal("grow same cycle length", int'(length), 4);
        applyStimulus("grow_alone", 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus("grow_wait", 0, 0, 0, 0, 0, 0, 0, 0);
        checkVal("pending grow not yet applied", int'(length), 4);
        applyStimulus("grow_late_tick", 1, 0, 0, 0, 0, 0, 0, 0);
        checkVal("pending grow applied", int'(length), 5);

        for (int i = 0; i < 20; i++) applyStimulus("saturate", 1, 0, 0, 0, 0, 1, 0, 0);
        checkVal("saturated length", int'(length), 23);

        guard = 0;
        while (bx[0] != 620 && guard < 40) begin
            applyStimulus("to_right_edge", 1, 0, 0, 0, 1, 0, 0, 0);
            guard++;
        end
        applyStimulus("wrap_right", 1, 0, 0, 0, 1, 0, 0, 0);
        checkVal("wrap right head x", int'(snakepos_x[10:0]), 0);
        guard = 0;
        while (by[0] != 0 && guard < 40) begin
            applyStimulus("to_top_edge", 1, 1, 0, 0, 0, 0, 0, 0);
            guard++;
        end
        applyStimulus("wrap_up", 1, 1, 0, 0, 0, 0, 0, 0);
        checkVal("wrap up head y", int'(snakepos_y[10:0]), 460);
        checkVal("wrap up head x", int'(snakepos_x[10:0]), 0);

        applyStimulus("reset1", 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus("halted", 1, 0, 0, 0, 0, 1, 1, 0);
        checkVal("halt head x", int'(snakepos_x[10:0]), 320);
        applyStimulus("unhalt_tick", 1, 0, 0, 0, 0, 0, 0, 0);
        checkVal("after halt length", int'(length), 3);
        checkVal("after halt head x", int'(snakepos_x[10:0]), 340);
        applyStimulus("grow_before_halt", 0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus("halt_keep_pend", 1, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus("retained_tick", 1, 0, 0, 0, 0, 0, 0, 0);
        checkVal("retained grow length", int'(length), 4);

        applyStimulus("grow5", 1, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus("grow6", 1, 0, 0, 0, 0, 1, 0, 0);
        checkVal("midgame length", int'(length), 6);
        applyStimulus("mid_reset", 1, 0, 0, 0, 0, 1, 0, 1);
        checkVal("mid reset length", int'(length), 3);
        checkVal("mid reset moved", int'(moved), 0);
        applyStimulus("post_reset_tick", 1, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            applyStimulus("random",
                $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
